// File: rtl/button_event_gen_if.sv
// Event stream from button_event_gen (master) to the menu/cursor consumer (slave).
// VALID/READY handshake; CODE and REPEAT describe the head of the event queue.
interface button_event_gen_if;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [2:0] EVT_CODE;
    logic       EVT_REPEAT;

    modport master (
        output EVT_VALID,
        output EVT_CODE,
        output EVT_REPEAT,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  EVT_CODE,
        input  EVT_REPEAT,
        output EVT_READY
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns debounced button levels into press pulses and a queued press/auto-repeat event stream.
// Auto-repeat (REPEAT state, hold timer) is compiled only when BTN_AUTOREPEAT_EN is defined.
module button_event_gen #(
    parameter int CLK_HZ          = 100000000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        CLK,
    input  logic                        CPU_RESET_N,
    input  logic [4:0]                  BTNDB_I,
    output logic [4:0]                  PRESS_PULSE,
    button_event_gen_if.master          evt,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW
);
    localparam int DLY   = CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int RPT   = CLK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef BTN_AUTOREPEAT_EN
    localparam int TMR_W   = $clog2((DLY > RPT) ? DLY : RPT) + 1;
    localparam int ENTRY_W = 4;
`else
    localparam int ENTRY_W = 3;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [1:0] ST_REPEAT = 2'd2;
`endif

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("button_event_gen: FIFO_DEPTH must be a power of 2 and at least 2");
        end
        if (DLY < 1 || RPT < 1) begin : g_bad_timing
            $error("button_event_gen: repeat delay and rate must be at least one clock cycle");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rising-edge pulses
    // ------------------------------------------------------------------
    logic [4:0] prev_reg;
    logic [4:0] pulse_reg;
    wire  [4:0] rise;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_rise
            assign rise[gi] = BTNDB_I[gi] & ~prev_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Active-button selection and event FSM
    // ------------------------------------------------------------------
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [2:0]         act_reg;
    logic [2:0]         act_next;
    logic               push_req_reg;
    logic               push_req_next;
    logic [ENTRY_W-1:0] push_entry_reg;
    logic [ENTRY_W-1:0] push_entry_next;
`ifdef BTN_AUTOREPEAT_EN
    logic [TMR_W-1:0]   timer_reg;
    logic [TMR_W-1:0]   timer_next;
`endif
    logic [2:0]         lowest_idx;
    logic               act_held;

    // Lowest set index wins when several buttons are down together.
    always_comb begin
        lowest_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (BTNDB_I[i]) begin
                lowest_idx = 3'(i);
            end
        end
    end

    assign act_held = BTNDB_I[act_reg];

    always_comb begin
        state_next      = state_reg;
        act_next        = act_reg;
        push_req_next   = 1'b0;
        push_entry_next = push_entry_reg;
`ifdef BTN_AUTOREPEAT_EN
        timer_next      = timer_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (BTNDB_I != 5'd0) begin
                    act_next      = lowest_idx;
                    push_req_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    push_entry_next = {1'b0, lowest_idx};
                    timer_next      = '0;
`else
                    push_entry_next = lowest_idx;
`endif
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!act_held) begin
                    state_next = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    timer_next = '0;
                end else if (timer_reg == TMR_W'(DLY - 1)) begin
                    push_req_next   = 1'b1;
                    push_entry_next = {1'b1, act_reg};
                    timer_next      = '0;
                    state_next      = ST_REPEAT;
                end else begin
                    timer_next = timer_reg + 1'b1;
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            ST_REPEAT: begin
                if (!act_held) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else if (timer_reg == TMR_W'(RPT - 1)) begin
                    push_req_next   = 1'b1;
                    push_entry_next = {1'b1, act_reg};
                    timer_next      = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CPU_RESET_N) begin
        if (!CPU_RESET_N) begin
            prev_reg       <= '0;
            pulse_reg      <= '0;
            state_reg      <= ST_IDLE;
            act_reg        <= '0;
            push_req_reg   <= 1'b0;
            push_entry_reg <= '0;
`ifdef BTN_AUTOREPEAT_EN
            timer_reg      <= '0;
`endif
        end else begin
            prev_reg       <= BTNDB_I;
            pulse_reg      <= rise;
            state_reg      <= state_next;
            act_reg        <= act_next;
            push_req_reg   <= push_req_next;
            push_entry_reg <= push_entry_next;
`ifdef BTN_AUTOREPEAT_EN
            timer_reg      <= timer_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [LVL_W-1:0]   level_next;
    logic               ovf_reg;
    logic               fifo_valid;
    logic               fifo_full;
    logic               pop;
    logic               wr_en;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    assign fifo_valid = (level_reg != '0);
    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    assign pop        = fifo_valid & evt.EVT_READY;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign wr_en      = push_req_reg & (~fifo_full | pop);
    assign drop       = push_req_reg & fifo_full & ~pop;

    always_comb begin
        level_next = level_reg;
        case ({wr_en, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_entry_reg;
        end
    end

    always_ff @(posedge CLK or negedge CPU_RESET_N) begin
        if (!CPU_RESET_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Memory is not reset, so head fields are masked while the queue is empty.
    assign head          = mem[rd_ptr_reg];
    assign evt.EVT_VALID = fifo_valid;
    assign evt.EVT_CODE  = fifo_valid ? head[2:0] : 3'd0;
`ifdef BTN_AUTOREPEAT_EN
    assign evt.EVT_REPEAT = fifo_valid & head[3];
`else
    assign evt.EVT_REPEAT = 1'b0;
`endif

    assign PRESS_PULSE = pulse_reg;
    assign FIFO_LEVEL  = level_reg;
    assign OVERFLOW    = ovf_reg;

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: vector table, directed corner sequences,
// and random stimulus checked against an event-list reference model.
module tb_button_event_gen;
    localparam int DLY   = 50;
    localparam int RPT   = 20;
    localparam int DEPTH = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_N = 4;
`else
    localparam int HOLD_N = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic [4:0] pulse;
    logic [2:0] level;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    button_event_gen_if evt_if ();

    button_event_gen #(
        .CLK_HZ          (10000),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .CLK         (clk),
        .CPU_RESET_N (rst_n),
        .BTNDB_I     (btn),
        .PRESS_PULSE (pulse),
        .evt         (evt_if),
        .FIFO_LEVEL  (level),
        .OVERFLOW    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] b);
        for (int i = 0; i < 5; i++) begin
            if (b[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: an event list built from the hold count of the selected button.
    logic [3:0] m_q[$];
    bit         m_pend;
    logic [3:0] m_pend_e;
    bit         m_ovf;
    bit         m_pop;
    logic [4:0] m_prev;
    logic [4:0] m_pulse;
    int         m_act;
    int         m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pend   = 0;
            m_pend_e = '0;
            m_ovf    = 0;
            m_prev   = '0;
            m_pulse  = '0;
            m_act    = -1;
            m_n      = 0;
        end else begin
            m_pop = (m_q.size() != 0) && (evt_if.EVT_READY === 1'b1);
            if (m_pop) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_e);
                else m_ovf = 1;
            end
            m_pend  = 0;
            m_pulse = btn & ~m_prev;
            m_prev  = btn;
            if (m_act < 0) begin
                if (btn != 5'd0) begin
                    m_act    = lowest(btn);
                    m_n      = 0;
                    m_pend   = 1;
                    m_pend_e = {1'b0, 3'(m_act)};
                end
            end else if (!btn[m_act]) begin
                m_act = -1;
            end else begin
                m_n++;
`ifdef BTN_AUTOREPEAT_EN
                if (m_n >= DLY && (m_n - DLY) % RPT == 0) begin
                    m_pend   = 1;
                    m_pend_e = {1'b1, 3'(m_act)};
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pulse_level_ovf", {pulse, evt_if.EVT_VALID, level, ovf},
                {m_pulse, (m_q.size() != 0), 3'(m_q.size()), m_ovf});
            if (m_q.size() != 0)
                chk("model_head", {evt_if.EVT_REPEAT, evt_if.EVT_CODE}, m_q[0]);
        end
    end

    typedef struct {
        logic [4:0] btn;
        logic       rdy;
        logic [4:0] pulse;
        logic       valid;
        logic [2:0] code;
        logic       rep;
        logic [2:0] level;
    } vec_t;

    vec_t       tbl[14];
    int         ev_i[$];
    logic [3:0] ev_d[$];
    logic [2:0] drained[$];

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        btn = 5'd0;
        evt_if.EVT_READY = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [4:0] b, input int hi, input int lo);
        btn = b;
        repeat (hi) @(negedge clk);
        btn = 5'd0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5'b00100, 1'b1, 5'b00100, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[1] = '{5'b00100, 1'b1, 5'b00000, 1'b1, 3'd2, 1'b0, 3'd1};
        tbl[2] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[3] = '{5'b00001, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[4] = '{5'b00001, 1'b1, 5'b00000, 1'b1, 3'd0, 1'b0, 3'd1};
        for (int i = 5; i < 13; i++) tbl[i] = '{5'b00001, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[13] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};

        // Reset with a button already held.
        rst_n = 1'b0;
        btn = 5'b00100;
        evt_if.EVT_READY = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pulse", pulse, 5'd0);
        chk("rst_valid", evt_if.EVT_VALID, 1'b0);
        chk("rst_code", evt_if.EVT_CODE, 3'd0);
        chk("rst_repeat", evt_if.EVT_REPEAT, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk_en = 1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            btn = tbl[i].btn;
            evt_if.EVT_READY = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i), pulse, tbl[i].pulse);
            chk($sformatf("tbl%0d_valid", i), evt_if.EVT_VALID, tbl[i].valid);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].level);
            if (tbl[i].valid)
                chk($sformatf("tbl%0d_head", i), {evt_if.EVT_REPEAT, evt_if.EVT_CODE},
                    {tbl[i].rep, tbl[i].code});
        end

        // Hold centre for 100 cycles with the consumer always ready.
        evt_if.EVT_READY = 1'b1;
        for (int i = 0; i < 140; i++) begin
            btn = (i < 100) ? 5'b10000 : 5'b00000;
            @(negedge clk);
            if (evt_if.EVT_VALID) begin
                ev_i.push_back(i);
                ev_d.push_back({evt_if.EVT_REPEAT, evt_if.EVT_CODE});
            end
        end
        chk("hold_count", ev_i.size(), HOLD_N);
        if (ev_i.size() > 0) chk("hold_first_latency", ev_i[0], 1);
        for (int k = 0; k < ev_i.size(); k++) begin
            chk($sformatf("hold_ev%0d", k), ev_d[k], {(k != 0), 3'd4});
            if (k > 0) chk($sformatf("hold_gap%0d", k), ev_i[k] - ev_i[k-1], (k == 1) ? DLY : RPT);
        end

        // Backpressure: six presses into a four-entry queue.
        evt_if.EVT_READY = 1'b0;
        for (int p = 0; p < 6; p++) press(5'b00010, 3, 3);
        chk("bp_level", level, 3'd4);
        chk("bp_ovf", ovf, 1'b1);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp_stall%0d", s), {evt_if.EVT_VALID, evt_if.EVT_REPEAT, evt_if.EVT_CODE}, 5'b1_0_001);
            @(negedge clk);
        end
        evt_if.EVT_READY = 1'b1;
        drained.delete();
        for (int j = 0; j < 10; j++) begin
            if (evt_if.EVT_VALID) begin
                drained.push_back(evt_if.EVT_CODE);
                chk($sformatf("bp_pop%0d_rep", j), evt_if.EVT_REPEAT, 1'b0);
            end
            @(negedge clk);
        end
        chk("bp_pops", drained.size(), 4);
        foreach (drained[k]) chk($sformatf("bp_pop%0d_code", k), drained[k], 3'd1);
        chk("bp_ovf_sticky", ovf, 1'b1);

        // Full queue: a new push lands in the same cycle as a pop.
        do_reset();
        for (int p = 0; p < 4; p++) press(5'b00010, 3, 3);
        chk("full_level", level, 3'd4);
        chk("full_ovf", ovf, 1'b0);
        btn = 5'b01000;
        @(negedge clk);
        evt_if.EVT_READY = 1'b1;
        @(negedge clk);
        evt_if.EVT_READY = 1'b0;
        btn = 5'd0;
        @(negedge clk);
        chk("pushpop_level", level, 3'd4);
        chk("pushpop_ovf", ovf, 1'b0);
        evt_if.EVT_READY = 1'b1;
        drained.delete();
        for (int j = 0; j < 12; j++) begin
            if (evt_if.EVT_VALID) drained.push_back(evt_if.EVT_CODE);
            @(negedge clk);
        end
        chk("pushpop_drain_count", drained.size(), 4);
        if (drained.size() == 4) chk("pushpop_last_code", drained[3], 3'd3);

        // Random stimulus against the reference model.
        for (int seg = 0; seg < 45; seg++) begin
            int dur;
            int mode;
            int stall;
            mode  = $urandom_range(0, 4);
            stall = ($urandom_range(0, 4) == 0);
            dur   = $urandom_range(1, 90);
            if (seg == 22) do_reset();
            case (mode)
                0, 1:    btn = 5'd0;
                2, 3:    btn = 5'd1 << $urandom_range(0, 4);
                default: btn = 5'($urandom_range(0, 31));
            endcase
            for (int c = 0; c < dur; c++) begin
                evt_if.EVT_READY = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
        end
        btn = 5'd0;
        evt_if.EVT_READY = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_drained", level, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Sits directly downstream of the 5-button debouncer and consumes its debounced level vector.
- Converts held levels into discrete press events: a one-cycle edge pulse per button, plus a queued event stream with hold-to-repeat.
- The event stream drives menu/cursor logic through a valid/ready handshake.
- A small FIFO absorbs events while the consumer is busy.

Parameters:
- CLK_HZ, 100000000: clock frequency in Hz.
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat event.
- REPEAT_RATE_MS, 100: interval between subsequent auto-repeat events.
- FIFO_DEPTH, 4: event queue depth; power of 2, minimum 2.

Ports:
- CLK  in  1: system clock. One clock domain only.
- CPU_RESET_N  in  1: reset, asynchronous, active-low.
- BTNDB_I  in  5: debounced levels. Bit 0 up, 1 left, 2 right, 3 down, 4 center.
- PRESS_PULSE  out  5: one-cycle rising-edge pulse per button. Unqueued.
- EVT_VALID  out  1: FIFO head holds an event.
- EVT_READY  in  1: consumer accepts the head event.
- EVT_CODE  out  3: head event button index, 0..4.
- EVT_REPEAT  out  1: head event is an auto-repeat; 0 = initial press.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1: entries queued.
- OVERFLOW  out  1: sticky, set when an event is dropped.

Behaviour:
- Reset (async assert, sync deassert) clears:
  - FSM to IDLE; previous-level register, timer, FIFO pointers;
  - all outputs to 0: PRESS_PULSE, EVT_VALID, EVT_CODE, EVT_REPEAT, FIFO_LEVEL, OVERFLOW.
  - A button held across reset release therefore yields a fresh press event.
- Timing constants:
  - DLY = CLK_HZ/1000*REPEAT_DELAY_MS cycles; RPT = CLK_HZ/1000*REPEAT_RATE_MS cycles.
  - Timer width = $clog2(max(DLY,RPT))+1. Timer never wraps; it clears on every push and on leaving HOLD/REPEAT.
- Edge pulse:
  - PRESS_PULSE[i] = BTNDB_I[i] & ~prev[i], registered. High for exactly the cycle after the first edge that samples the bit high.
  - Multiple simultaneous rising bits all pulse.
- FSM IDLE: if BTNDB_I != 0, select the lowest set index as ACT, request push {repeat=0, code=ACT}, clear timer, go to HOLD.
- FSM HOLD:
  - If BTNDB_I[ACT]=0, go to IDLE.
  - Otherwise increment timer. When timer reaches DLY-1, request push {1, ACT}, clear timer, go to REPEAT.
- FSM REPEAT:
  - If BTNDB_I[ACT]=0, go to IDLE.
  - Otherwise every RPT cycles, request push {1, ACT}.
- Other buttons while ACT is held: ignored by the queue (PRESS_PULSE still fires). On ACT release, IDLE re-selects any still-held button next cycle and queues a new press.
- Push latency:
  - The push request is registered at edge e0 (the edge that samples the level); the FIFO write happens at e1.
  - EVT_VALID rises after e1, i.e. 2 cycles after the input rises when the FIFO is empty.
- FIFO:
  - Entries are {repeat, code}; the head drives EVT_CODE/EVT_REPEAT directly. EVT_VALID = (level != 0).
  - Pop on EVT_VALID & EVT_READY. Head outputs are stable while VALID & ~READY.
  - EVT_CODE/EVT_REPEAT are don't-care when EVT_VALID=0, but must be 0 after reset.
- FIFO boundary conditions:
  - Push when full without a pop: event dropped, OVERFLOW set until reset.
  - Push and pop in the same cycle when full: both occur, level unchanged, no overflow.
  - Push and pop together when empty is impossible, since VALID=0.
- Pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL saturates at FIFO_DEPTH by construction.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: HOLD/REPEAT behaviour as above.
- Undefined:
  - The REPEAT state and repeat logic are not compiled.
  - HOLD only waits for ACT release, with no timer increment.
  - EVT_REPEAT is tied to 0. One event per press.

Test Plan:
- Bench parameters: CLK_HZ=10000, REPEAT_DELAY_MS=5 (DLY=50), REPEAT_RATE_MS=2 (RPT=20), FIFO_DEPTH=4.
- Reset: hold CPU_RESET_N=0 with BTNDB_I=5'b00100 -> all outputs 0. Release -> PRESS_PULSE=5'b00100 for 1 cycle; EVT_VALID with CODE=2, REPEAT=0, 2 cycles after release.
- Short press: BTNDB_I=5'b00001 for 10 cycles, READY=1 -> exactly one event {0,0}; PRESS_PULSE[0] one cycle; FIFO_LEVEL returns to 0.
- Hold with repeat: BTNDB_I=5'b10000 for 100 cycles, READY=1 -> events {0,4}, then {1,4} 50 cycles later, then {1,4} 20 and 40 cycles after that. None after release.
- Backpressure/overflow: READY=0, six short presses of button 1 -> FIFO_LEVEL=4, OVERFLOW=1. Raise READY -> four {0,1} pops, with the head stable until each handshake.
- Full push+pop: FIFO full, READY=1 in the same cycle as a new press push -> FIFO_LEVEL stays 4, OVERFLOW stays 0.
- Macro off: repeat the hold-with-repeat case -> a single event {0,4}, and EVT_REPEAT never 1.
